// File: rtl/rv32im_pkg.sv
// Shared types and constants for the rv32im pipeline front end.
// Fetch-buffer entries pair each instruction word with the PC it was fetched from.
package rv32im_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/rv32im_fetch_buf.sv
// 2-entry fetch FIFO with head peek; a push shows up at the head one cycle later. Push and pop may coincide.
// No backpressure of its own: the owner's credit accounting keeps occupancy at 2 or below.
module rv32im_fetch_buf
    import rv32im_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [63:0] push_entry,
    input  logic        pop,
    output logic [63:0] head,
    output logic [1:0]  count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rv32im_fetch_stage.sv
// Fetch stage: in-order imem requests, 2-deep response buffer, IF/ID register; a response lands in IF/ID one cycle after it arrives.
// Stalls hold IF/ID while requests are credit-limited; redirects flush. RV32IM_FETCH_ALIGN_CHECK_EN adds misaligned_d.
module rv32im_fetch_stage
    import rv32im_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] PCF,
    output logic        valid_d,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
`ifdef RV32IM_FETCH_ALIGN_CHECK_EN
    ,
    output logic        misaligned_d
`endif
);

    logic [1:0]   outstanding;
    logic [1:0]   outstanding_next;
    logic [1:0]   drop_count;
    logic [1:0]   buf_count;
    logic [2:0]   in_flight;
    logic [31:0]  resp_pc;
    logic [31:0]  target;
    logic         fetch_block;
    logic         req_fire;
    logic         rsp_fire;
    logic         rsp_keep;
    logic         load_ifid;
    logic         buf_push;
    logic         buf_pop;
    logic         ifid_src_vld;
    fetch_entry_t buf_head;
    fetch_entry_t rsp_entry;
    fetch_entry_t ifid_src;

`ifdef RV32IM_FETCH_ALIGN_CHECK_EN
    logic misalign_hold;
    logic misalign_slot;

    assign target      = redirect_pc;
    assign fetch_block = misalign_hold;
`else
    logic unused_redirect_lsb;

    assign target              = {redirect_pc[31:2], 2'b00};
    assign fetch_block         = 1'b0;
    assign unused_redirect_lsb = |redirect_pc[1:0];
`endif

    // Credit: every issued request already has a buffer slot reserved.
    assign in_flight      = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = !reset && !redirect_valid && !fetch_block && (in_flight < 3'd2);
    assign imem_req_addr  = PCF;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_fire  = imem_rsp_valid && (outstanding != 2'd0);
    assign rsp_keep  = rsp_fire && (drop_count == 2'd0) && !redirect_valid;
    assign rsp_entry = '{pc: resp_pc, instr: imem_rsp_data};

    assign load_ifid    = !stall_d || !valid_d;
    assign buf_pop      = load_ifid && (buf_count != 2'd0) && !redirect_valid;
    assign buf_push     = rsp_keep && !(load_ifid && (buf_count == 2'd0));
    assign ifid_src     = (buf_count != 2'd0) ? buf_head : rsp_entry;
    assign ifid_src_vld = (buf_count != 2'd0) || rsp_keep;

    assign outstanding_next = outstanding + {1'b0, req_fire} - {1'b0, rsp_fire};

    rv32im_fetch_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_valid),
        .push       (buf_push),
        .push_entry (rsp_entry),
        .pop        (buf_pop),
        .head       (buf_head),
        .count      (buf_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            PCF         <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= 2'd0;
            drop_count  <= 2'd0;
            valid_d     <= 1'b0;
            InstrD      <= RV_NOP;
            PCD         <= 32'd0;
            PCPlus4D    <= 32'd4;
`ifdef RV32IM_FETCH_ALIGN_CHECK_EN
            misalign_hold <= 1'b0;
            misalign_slot <= 1'b0;
            misaligned_d  <= 1'b0;
`endif
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight, including this cycle's response, is wrong-path.
                PCF        <= target;
                resp_pc    <= target;
                drop_count <= outstanding_next;
                valid_d    <= 1'b0;
                InstrD     <= RV_NOP;
`ifdef RV32IM_FETCH_ALIGN_CHECK_EN
                misalign_hold <= (target[1:0] != 2'b00);
                misalign_slot <= (target[1:0] != 2'b00);
                misaligned_d  <= 1'b0;
`endif
            end else begin
                if (req_fire) begin
                    PCF <= PCF + 32'd4;
                end
                if (rsp_fire && (drop_count != 2'd0)) begin
                    drop_count <= drop_count - 2'd1;
                end
                if (rsp_keep) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (load_ifid) begin
`ifdef RV32IM_FETCH_ALIGN_CHECK_EN
                    misaligned_d  <= misalign_slot;
                    misalign_slot <= 1'b0;
                    if (misalign_slot) begin
                        valid_d  <= 1'b1;
                        InstrD   <= RV_NOP;
                        PCD      <= resp_pc;
                        PCPlus4D <= resp_pc + 32'd4;
                    end else
`endif
                    if (ifid_src_vld) begin
                        valid_d  <= 1'b1;
                        InstrD   <= ifid_src.instr;
                        PCD      <= ifid_src.pc;
                        PCPlus4D <= ifid_src.pc + 32'd4;
                    end else begin
                        valid_d <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/rv32im_fetch_stage.md
# rv32im_fetch_stage

Instruction fetch stage of the pipelined `rv32im_processor`, feeding the decode stage. It owns the fetch PC (`PCF`) and issues in-order word requests to instruction memory over a valid/ready handshake. Responses are buffered in a 2-entry queue and drive the IF/ID pipeline register (`InstrD`, `PCD`, `PCPlus4D`). It honours decode stalls and execute-stage redirects, discarding wrong-path responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: value loaded into `PCF` on reset.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  request valid.
- `imem_req_addr`  out  32  request address; always equals `PCF`.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_rsp_valid`  in  1  response word valid.
- `imem_rsp_data`  in  32  instruction word, in request order.
- `stall_d`  in  1  decode cannot accept; hold IF/ID.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  redirect target.
- `PCF`  out  32  current fetch PC.
- `valid_d`  out  1  IF/ID holds a real instruction.
- `InstrD`  out  32  instruction to decode.
- `PCD`  out  32  PC of `InstrD`.
- `PCPlus4D`  out  32  `PCD + 4`, mod 2^32.

## Operation
- Request: `imem_req_valid = !reset && !redirect_valid && (outstanding + buf_count) < 2`. On accept (`valid && ready`), `PCF <= PCF + 4` (32-bit wrap), `outstanding++`.
- Response: `outstanding--`. If `drop_count > 0`, the response is discarded and `drop_count--`. Otherwise it is enqueued with its PC. A per-entry PC is tracked from a shadow `resp_pc` register that advances by 4 per kept response.
- IF/ID load: when `!stall_d || !valid_d`, load from the buffer head. If the buffer is empty, an arriving kept response bypasses straight into IF/ID. If nothing is available, `valid_d <= 0`.
- With `stall_d && valid_d`, IF/ID holds. Responses still enqueue; the credit rule guarantees no overflow.
- Redirect (priority over stall and all other events):
  - `PCF <= redirect_pc`; `resp_pc <= redirect_pc`; buffer cleared; `valid_d <= 0`, `InstrD <= NOP`.
  - `drop_count <=` outstanding after this cycle's request/response accounting. No request is issued in the redirect cycle.
- Reset values:
  - `PCF = RESET_PC`, `resp_pc = RESET_PC`.
  - `valid_d = 0`, `InstrD = 32'h0000_0013` (NOP), `PCD = 0`, `PCPlus4D = 4`.
  - Buffer, `outstanding` and `drop_count` all 0.
- Reset mid-operation discards everything. In-flight responses arriving after reset are not dropped; the memory is reset on the same `reset`.

## Timing
- Request accepted in cycle N, response in N+k (k ≥ 1). With the buffer empty and no stall, `valid_d` and `InstrD` are registered at the end of N+k, i.e. visible in N+k+1.
- Sustained throughput is 1 instruction/cycle with k = 1 and `imem_req_ready` held at 1.
- Redirect in cycle R: first request to `redirect_pc` in R+1; first `valid_d` no earlier than R+3 with k = 1.
- Simultaneous response and redirect: the response counts toward `drop_count` accounting and is discarded.

## Configuration
- `RV32IM_FETCH_ALIGN_CHECK_EN` defined:
  - Adds output `misaligned_d` (1 bit, reset 0).
  - A redirect with `redirect_pc[1:0] != 0` suppresses all requests until the next redirect.
  - On the next IF/ID load it presents `valid_d = 1`, `misaligned_d = 1`, `InstrD = NOP`, `PCD = redirect_pc`.
- Not defined: the port is absent and `redirect_pc[1:0]` is forced to 2'b00.

## Structure
- `rv32im_pkg` holds: `RV_NOP = 32'h0000_0013`, `XLEN = 32`, and the fetch-buffer entry typedef `{pc[31:0], instr[31:0]}`.
- One sub-module: `rv32im_fetch_buf`, a 2-entry FIFO with synchronous `clear`, `count`, and head peek/pop.

## Test plan
- Reset release with `RESET_PC = 32'h100`, memory k = 1, always ready: requests at 0x100, 0x104, 0x108 on consecutive cycles; `PCD` = 0x100 with `valid_d` two cycles after the first accept, then +4 every cycle.
- `stall_d` held 3 cycles after instruction at 0x104 enters IF/ID: IF/ID holds 0x104; `imem_req_valid` drops once outstanding + buffered = 2; after release, 0x108 and 0x10C follow with no loss or duplication.
- Redirect to 0x200 with 2 requests outstanding (k = 2): both old responses dropped; next `valid_d` shows `PCD` = 0x200, `InstrD` = mem[0x200].
- Redirect asserted together with `stall_d` and a response: redirect wins; `valid_d` = 0 next cycle and the response is discarded.
- `PCF` at 0xFFFF_FFFC: next request wraps to 0x0000_0000; `PCPlus4D` = 0 for that instruction.
- (`RV32IM_FETCH_ALIGN_CHECK_EN`) redirect to 0x202: no requests; one slot with `misaligned_d` = 1 and `PCD` = 0x202; redirect to 0x300 resumes normal fetch.
